// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the 5-stage MIPS core (ID/EX, EX/MEM, MEM/WB).
// Adds hold/bubble control, Tnew countdown, exception merge, EPC retention and a stall counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned WA_W   = 5,
  parameter int unsigned TNEW_W = 2,
  parameter int unsigned EXC_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              keep_pc_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] rd2_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              grf_we_i,
  input  logic [WA_W-1:0]   wa_i,
  input  logic [TNEW_W-1:0] tnew_i,
  input  logic [EXC_W-1:0]  exc_i,
  input  logic [EXC_W-1:0]  exc_local_i,
  input  logic              bd_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] pc8_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] rd2_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              grf_we_o,
  output logic [WA_W-1:0]   wa_o,
  output logic [TNEW_W-1:0] tnew_o,
  output logic [EXC_W-1:0]  exc_o,
  output logic              bd_o,
  output logic              fwd_ready_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [TNEW_W-1:0] tnew_dec;
  logic [EXC_W-1:0]  exc_merged;

  // Tnew counts down toward zero and sticks there; the earlier-stage fault has priority.
  assign tnew_dec   = (tnew_i == '0) ? '0 : tnew_i - TNEW_W'(1);
  assign exc_merged = !valid_i ? '0 : ((exc_i != '0) ? exc_i : exc_local_i);

  // Priority: reset > flush > stall > advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o     <= 1'b0;
      pc_o        <= '0;
      alu_o       <= '0;
      rd2_o       <= '0;
      ctrl_o      <= '0;
      grf_we_o    <= 1'b0;
      wa_o        <= '0;
      tnew_o      <= '0;
      exc_o       <= '0;
      bd_o        <= 1'b0;
      stall_cnt_o <= '0;
    end else if (flush_i) begin
      valid_o  <= 1'b0;
      alu_o    <= '0;
      rd2_o    <= '0;
      ctrl_o   <= '0;
      grf_we_o <= 1'b0;
      wa_o     <= '0;
      tnew_o   <= '0;
      exc_o    <= '0;
      // Bubble may keep the flushed PC/delay-slot flag so EPC stays recoverable.
      pc_o     <= keep_pc_i ? pc_i : '0;
      bd_o     <= keep_pc_i & bd_i;
    end else if (stall_i) begin
      if (stall_cnt_o != {CNT_W{1'b1}}) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end else begin
      valid_o  <= valid_i;
      pc_o     <= pc_i;
      alu_o    <= alu_i;
      rd2_o    <= rd2_i;
      ctrl_o   <= ctrl_i;
      bd_o     <= bd_i;
      grf_we_o <= grf_we_i & valid_i;
      wa_o     <= valid_i ? wa_i : '0;
      tnew_o   <= tnew_dec;
      exc_o    <= exc_merged;
    end
  end

  assign pc8_o       = pc_o + DATA_W'(8);
  assign fwd_ready_o = valid_o & grf_we_o & (wa_o != '0) & (tnew_o == '0);

endmodule
